// File: rtl/usb_rx_deserializer.sv
// Serial-to-parallel receiver: accumulates accepted bits into DATA_WIDTH-bit words and hands
// completed words to the consumer through a holding register with valid/ack and overrun flag.
module usb_rx_deserializer #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter bit          SHIFT_MSB  = 1'b0
) (
   input  logic                              clk,
   input  logic                              n_rst,
   input  logic                              clear,
   input  logic                              shift_enable,
   input  logic                              skip_bit,
   input  logic                              d_orig,
   input  logic                              word_ack,
   output logic [DATA_WIDTH-1:0]             rcv_data,
   output logic [$clog2(DATA_WIDTH+1)-1:0]   bit_count,
   output logic [DATA_WIDTH-1:0]             word_data,
   output logic                              word_valid,
   output logic                              overrun
);

   localparam int unsigned CntW = $clog2(DATA_WIDTH + 1);
   localparam logic [CntW-1:0] LastBit = CntW'(DATA_WIDTH - 1);

   logic                  accept;
   logic                  complete;
   logic [DATA_WIDTH-1:0] shifted;

   always_comb begin
      accept   = shift_enable & ~skip_bit;
      complete = accept & ~clear & (bit_count == LastBit);
      if (SHIFT_MSB) begin
         shifted = {rcv_data[DATA_WIDTH-2:0], d_orig};
      end else begin
         shifted = {d_orig, rcv_data[DATA_WIDTH-1:1]};
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         rcv_data   <= '1;
         bit_count  <= '0;
         word_data  <= '1;
         word_valid <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         // clear flushes the partial word only; the holding register is left to the consumer
         if (clear) begin
            rcv_data  <= '1;
            bit_count <= '0;
            overrun   <= 1'b0;
         end else if (accept) begin
            rcv_data  <= shifted;
            bit_count <= complete ? '0 : bit_count + 1'b1;
         end

         if (complete) begin
            word_data  <= shifted;
            word_valid <= 1'b1;
            if (word_valid && !word_ack) begin
               overrun <= 1'b1;
            end
         end else if (word_ack) begin
            word_valid <= 1'b0;
         end
      end
   end

endmodule

// File: doc/usb_rx_deserializer.md
Name: usb_rx_deserializer

Overview:
Parametrised successor to the USB receiver's fixed 8-bit shift register. Deserialises decoded, unstuffed NRZI bits into DATA_WIDTH-bit words with selectable bit order. Ignores bits flagged as stuffed and counts bits toward a word boundary. Completed words go into a holding register with a valid/ack handshake and sticky overrun detection, so the RX control FSM and RX FIFO no longer poll a free-running shift register.

Parameters:
DATA_WIDTH, 8, word width in bits; legal range 2..32.
SHIFT_MSB, 0, bit order. 0 means a new bit enters at the MSB and the register shifts right (LSB-first, USB order). 1 means a new bit enters at the LSB and the register shifts left.

Ports:
clk  input  1  system clock, rising-edge.
n_rst  input  1  asynchronous active-low reset.
clear  input  1  synchronous flush of the partial word and the overrun flag (driven at SOP/EOP).
shift_enable  input  1  one-cycle strobe; d_orig holds a valid bit-time sample.
skip_bit  input  1  qualifies shift_enable; this bit is a stuffed bit and must be discarded.
d_orig  input  1  decoded serial data bit.
word_ack  input  1  consumer accepts word_data this cycle.
rcv_data  output  DATA_WIDTH  live shift register contents.
bit_count  output  $clog2(DATA_WIDTH+1)  bits accumulated in the current partial word.
word_data  output  DATA_WIDTH  holding register with the last completed word.
word_valid  output  1  word_data holds an unacknowledged word.
overrun  output  1  sticky flag: a word completed while the previous one was unacknowledged.

Behaviour:
- Clock and reset: one clock, clk. Reset n_rst is asynchronous and active-low.
- Reset values: rcv_data all ones (idle J), bit_count 0, word_data all ones, word_valid 0, overrun 0. Reset mid-word discards everything with no word_valid pulse.
- Accepted bit: shift_enable=1 and skip_bit=0. skip_bit with shift_enable=0 is ignored. shift_enable with skip_bit=1 changes no state.
- Shift rule, SHIFT_MSB=0: rcv_data <= {d_orig, rcv_data[DATA_WIDTH-1:1]}.
- Shift rule, SHIFT_MSB=1: rcv_data <= {rcv_data[DATA_WIDTH-2:0], d_orig}.
- bit_count increments on each accepted bit.
- Word completion: an accepted bit with bit_count == DATA_WIDTH-1.
  - bit_count wraps to 0.
  - On the same edge, word_data <= the post-shift value of rcv_data and word_valid <= 1.
  - Latency: word_valid and word_data are visible one cycle after the strobe cycle, coincident with the rcv_data update.
- Handshake:
  - word_valid=1 and word_ack=1 with no completion that cycle: word_valid goes to 0 next cycle.
  - word_ack while word_valid=0 is ignored.
  - Completion with word_ack=1 in the same cycle: new word loaded, word_valid stays 1, no overrun.
  - Completion with word_valid=1 and word_ack=0: word_data is overwritten with the new word, word_valid stays 1, overrun <= 1.
- overrun holds until clear or reset.
- clear has priority over shift and produces:
  - rcv_data <= all ones;
  - bit_count <= 0;
  - overrun <= 0;
  - no word completion that cycle.
- clear does not touch word_data or word_valid. A pending word survives an EOP flush; word_ack is still honoured in a clear cycle.
- rcv_data and bit_count remain stable between strobes; back-to-back strobes on consecutive cycles are legal.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
- Reset then 8 accepted strobes with d_orig = 1,0,1,0,0,1,0,1 (DATA_WIDTH=8, SHIFT_MSB=0) -> word_valid=1 one cycle after the 8th strobe, word_data=8'hA5, bit_count=0; after word_ack, word_valid=0 next cycle.
- Same bit sequence with SHIFT_MSB=1 -> word_data=8'hA5 bit-reversed = 8'hA5 reversed gives 8'hA5; use the sequence 1,1,0,0,0,0,0,0 instead -> word_data=8'hC0 for SHIFT_MSB=1 and 8'h03 for SHIFT_MSB=0.
- Sequence of 9 strobes where the 4th has skip_bit=1 -> the skipped bit is absent from word_data, and completion occurs on the 9th strobe.
- Two full words with no word_ack -> overrun=1, word_data = second word, word_valid=1. Repeat with word_ack asserted on the second completion cycle -> overrun stays 0.
- 5 accepted bits, then clear -> rcv_data=8'hFF, bit_count=0, no word_valid. A pending word_valid from earlier is retained through the clear.
- Assert n_rst low asynchronously mid-word, between clock edges -> all outputs take their reset values immediately. DATA_WIDTH=12 regression: completion after exactly 12 accepted bits.
